magia_tile_boot_seq: RTL and testbench

//  Parametrised boot/run sequencer for simulation fixtures holding N_TILES MAGIA tiles (replaces per-tile hand-driven stimulus).

---
 rtl/magia_tile_boot_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_magia_tile_boot_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/magia_tile_boot_seq.sv
// Boot/run sequencer for a fixture of N_TILES MAGIA tiles: reset hold, enable, staggered
// fetch launch, EOC collection with optional timeout, and a single pass/fail verdict.
module magia_tile_boot_seq #(
    parameter int unsigned N_TILES      = 4,
    parameter int unsigned HARTID_BASE  = 0,
    parameter int unsigned RST_HOLD_CYC = 16,
    parameter int unsigned STAGGER_CYC  = 8,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [CNT_W-1:0]        timeout_cyc_i,
    input  logic [31:0]             boot_addr_i,
    input  logic [N_TILES-1:0]      eoc_i,
    input  logic [N_TILES*8-1:0]    eoc_code_i,
    output logic [N_TILES-1:0]      tile_rst_no,
    output logic [N_TILES-1:0]      tile_enable_o,
    output logic [N_TILES-1:0]      fetch_en_o,
    output logic [31:0]             boot_addr_o,
    output logic [N_TILES*32-1:0]   mhartid_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic                    timeout_o,
    output logic [N_TILES-1:0]      fail_mask_o,
    output logic [CNT_W-1:0]        cycles_o
);

    localparam int unsigned HOLD_W    = $clog2(RST_HOLD_CYC + 1) + 1;
    localparam int unsigned HOLD_LAST = RST_HOLD_CYC - 1;
    localparam int unsigned STG_W     = $clog2(STAGGER_CYC + 1) + 1;
    localparam int unsigned STG_LAST  = (STAGGER_CYC == 0) ? 0 : STAGGER_CYC - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_ENABLE, S_LAUNCH, S_RUN, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [STG_W-1:0]    stg_cnt_q, stg_cnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    tmo_cyc_q, tmo_cyc_d;
    logic [31:0]         boot_addr_q, boot_addr_d;
    logic [N_TILES-1:0]  seen_q, seen_d;
    logic [N_TILES-1:0]  fail_q, fail_d;
    logic [N_TILES-1:0]  tile_rst_n_q, tile_rst_n_d;
    logic [N_TILES-1:0]  tile_en_q, tile_en_d;
    logic [N_TILES-1:0]  fetch_en_q, fetch_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;

    logic                active;
    logic [N_TILES-1:0]  code_nz;
    logic [N_TILES-1:0]  accept;
    logic [N_TILES-1:0]  seen_acc;
    logic                all_seen;
    logic                tmo_hit;
    logic                tmo_fin;
    logic [N_TILES-1:0]  fail_fin;
    logic                hold_end;

    // EOCs are captured before the timeout is judged, so a last-cycle EOC still counts
    always_comb begin
        code_nz = '0;
        for (int k = 0; k < N_TILES; k++) begin
            code_nz[k] = |eoc_code_i[k*8 +: 8];
        end
    end

    assign active   = (state_q == S_LAUNCH) || (state_q == S_RUN);
    assign accept   = active ? (eoc_i & fetch_en_q & ~seen_q) : '0;
    assign seen_acc = seen_q | accept;
    assign all_seen = active && (&seen_acc);
    assign tmo_hit  = active && (tmo_cyc_q != '0) && (cnt_q == tmo_cyc_q);
    assign tmo_fin  = tmo_hit && !all_seen;
    assign fail_fin = fail_q | (accept & code_nz) | (tmo_fin ? ~seen_acc : '0);
    assign hold_end = (hold_cnt_q == HOLD_W'(HOLD_LAST));

    // State register and all registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            stg_cnt_q    <= '0;
            cnt_q        <= '0;
            tmo_cyc_q    <= '0;
            boot_addr_q  <= '0;
            seen_q       <= '0;
            fail_q       <= '0;
            tile_rst_n_q <= '0;
            tile_en_q    <= '0;
            fetch_en_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            stg_cnt_q    <= stg_cnt_d;
            cnt_q        <= cnt_d;
            tmo_cyc_q    <= tmo_cyc_d;
            boot_addr_q  <= boot_addr_d;
            seen_q       <= seen_d;
            fail_q       <= fail_d;
            tile_rst_n_q <= tile_rst_n_d;
            tile_en_q    <= tile_en_d;
            fetch_en_q   <= fetch_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start_i) state_d = S_HOLD;
            S_HOLD:         if (hold_end) state_d = S_ENABLE;
            S_ENABLE:       state_d = S_LAUNCH;
            S_LAUNCH, S_RUN: begin
                if (all_seen || tmo_hit) begin
                    state_d = S_DONE;
                end else if ((state_q == S_LAUNCH) && (&fetch_en_q)) begin
                    state_d = S_RUN;
                end
            end
            default:        state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        stg_cnt_d    = stg_cnt_q;
        cnt_d        = cnt_q;
        tmo_cyc_d    = tmo_cyc_q;
        boot_addr_d  = boot_addr_q;
        seen_d       = seen_q;
        fail_d       = fail_q;
        tile_rst_n_d = tile_rst_n_q;
        tile_en_d    = tile_en_q;
        fetch_en_d   = fetch_en_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    boot_addr_d  = boot_addr_i;
                    tmo_cyc_d    = timeout_cyc_i;
                    hold_cnt_d   = '0;
                    cnt_d        = '0;
                    seen_d       = '0;
                    fail_d       = '0;
                    tile_rst_n_d = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                end
            end
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_end) begin
                    tile_rst_n_d = '1;
                    tile_en_d    = '1;
                end
            end
            S_ENABLE: begin
                fetch_en_d = (STAGGER_CYC == 0) ? '1 : N_TILES'(1);
                stg_cnt_d  = '0;
                cnt_d      = '0;
            end
            S_LAUNCH, S_RUN: begin
                seen_d = seen_acc;
                fail_d = fail_q | (accept & code_nz);
                if (all_seen || tmo_hit) begin
                    // cycles_o holds the counter value of the cycle that ended the run
                    fail_d     = fail_fin;
                    timeout_d  = tmo_fin;
                    pass_d     = !tmo_fin && (fail_fin == '0);
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    fetch_en_d = '0;
                    tile_en_d  = '0;
                end else begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    if ((state_q == S_LAUNCH) && !(&fetch_en_q)) begin
                        if (stg_cnt_q == STG_W'(STG_LAST)) begin
                            stg_cnt_d  = '0;
                            fetch_en_d = (fetch_en_q << 1) | N_TILES'(1);
                        end else begin
                            stg_cnt_d = stg_cnt_q + STG_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < N_TILES; g++) begin : g_hartid
            assign mhartid_o[g*32 +: 32] = 32'(HARTID_BASE + g);
        end
    endgenerate

    assign tile_rst_no   = tile_rst_n_q;
    assign tile_enable_o = tile_en_q;
    assign fetch_en_o    = fetch_en_q;
    assign boot_addr_o   = boot_addr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign timeout_o     = timeout_q;
    assign fail_mask_o   = fail_q;
    assign cycles_o      = cnt_q;

endmodule

// File: tb/tb_magia_tile_boot_seq.sv
// Bench for magia_tile_boot_seq: directed and random EOC schedules checked cycle by cycle
// against a timeline/event model of the boot sequence.
module tb_magia_tile_boot_seq;

    localparam int unsigned N  = 4;
    localparam int unsigned HB = 3;
    localparam int unsigned RH = 16;
    localparam int unsigned ST = 8;
    localparam int unsigned CW = 32;
    localparam int          L  = RH + 1;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [CW-1:0]     timeout_cyc_i;
    logic [31:0]       boot_addr_i;
    logic [N-1:0]      eoc_i;
    logic [N*8-1:0]    eoc_code_i;
    logic [N-1:0]      tile_rst_no;
    logic [N-1:0]      tile_enable_o;
    logic [N-1:0]      fetch_en_o;
    logic [31:0]       boot_addr_o;
    logic [N*32-1:0]   mhartid_o;
    logic              busy_o, done_o, pass_o, timeout_o;
    logic [N-1:0]      fail_mask_o;
    logic [CW-1:0]     cycles_o;

    always #5 clk = ~clk;

    magia_tile_boot_seq #(
        .N_TILES(N), .HARTID_BASE(HB), .RST_HOLD_CYC(RH), .STAGGER_CYC(ST), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .timeout_cyc_i(timeout_cyc_i),
        .boot_addr_i(boot_addr_i), .eoc_i(eoc_i), .eoc_code_i(eoc_code_i),
        .tile_rst_no(tile_rst_no), .tile_enable_o(tile_enable_o), .fetch_en_o(fetch_en_o),
        .boot_addr_o(boot_addr_o), .mhartid_o(mhartid_o), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .timeout_o(timeout_o), .fail_mask_o(fail_mask_o), .cycles_o(cycles_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // EOC schedule: ev_c is the launch-relative cycle of each pulse (-100 = unused slot)
    int            ev_c[N][3];
    logic [7:0]    ev_code[N][3];
    int            exp_end;
    bit            exp_tmo;
    logic [N-1:0]  exp_fail;

    task automatic clear_ev();
        for (int k = 0; k < N; k++)
            for (int e = 0; e < 3; e++) begin
                ev_c[k][e]    = -100;
                ev_code[k][e] = 8'h0;
            end
    endtask

    // Walk launch-relative cycles: first accepted pulse per launched tile wins
    task automatic model(input int t);
        logic [N-1:0] seen;
        seen     = '0;
        exp_fail = '0;
        exp_tmo  = 1'b0;
        exp_end  = -1;
        for (int c = 0; c < 4000 && exp_end < 0; c++) begin
            for (int k = 0; k < N; k++)
                for (int e = 0; e < 3; e++)
                    if (ev_c[k][e] == c && c >= int'(ST) * k && !seen[k]) begin
                        seen[k] = 1'b1;
                        if (ev_code[k][e] != 8'h0) exp_fail[k] = 1'b1;
                    end
            if (&seen) begin
                exp_end = c;
            end else if (t != 0 && c == t) begin
                exp_end  = c;
                exp_tmo  = 1'b1;
                exp_fail = exp_fail | ~seen;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rstn"},  64'(tile_rst_no),   64'h0);
        check({tag, "_en"},    64'(tile_enable_o), 64'h0);
        check({tag, "_fetch"}, 64'(fetch_en_o),    64'h0);
        check({tag, "_busy"},  64'(busy_o),        64'h0);
        check({tag, "_done"},  64'(done_o),        64'h0);
        check({tag, "_pass"},  64'(pass_o),        64'h0);
        check({tag, "_tmo"},   64'(timeout_o),     64'h0);
        check({tag, "_fail"},  64'(fail_mask_o),   64'h0);
        check({tag, "_cyc"},   64'(cycles_o),      64'h0);
        check({tag, "_boot"},  64'(boot_addr_o),   64'h0);
    endtask

    task automatic run_seq(input string name, input int t);
        logic [31:0] ba;
        logic [N-1:0] e_fetch;
        int last;
        int c;
        model(t);
        ba            = $urandom;
        boot_addr_i   = ba;
        timeout_cyc_i = CW'(t);
        start_i       = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        last = L + exp_end + 3;
        for (int i = 0; i <= last; i++) begin
            c = i - L;
            eoc_i      = '0;
            eoc_code_i = $urandom;
            for (int k = 0; k < N; k++)
                for (int e = 0; e < 3; e++)
                    if (ev_c[k][e] == c) begin
                        eoc_i[k]            = 1'b1;
                        eoc_code_i[k*8 +: 8] = ev_code[k][e];
                    end
            if (i <= L + exp_end) begin
                boot_addr_i   = $urandom;
                timeout_cyc_i = $urandom;
                start_i       = ($urandom_range(0, 15) == 0);
            end else begin
                start_i = 1'b0;
            end
            check({name, "_boot"}, 64'(boot_addr_o), 64'(ba));
            if (i < RH) begin
                check({name, "_hold_rstn"}, 64'(tile_rst_no),   64'h0);
                check({name, "_hold_en"},   64'(tile_enable_o), 64'h0);
                check({name, "_hold_busy"}, 64'(busy_o),        64'h1);
                check({name, "_hold_done"}, 64'(done_o),        64'h0);
                check({name, "_hold_cyc"},  64'(cycles_o),      64'h0);
                check({name, "_hold_fail"}, 64'(fail_mask_o),   64'h0);
            end else if (i == RH) begin
                check({name, "_ena_rstn"},  64'(tile_rst_no),   64'hF);
                check({name, "_ena_en"},    64'(tile_enable_o), 64'hF);
                check({name, "_ena_fetch"}, 64'(fetch_en_o),    64'h0);
                check({name, "_ena_busy"},  64'(busy_o),        64'h1);
            end else if (c <= exp_end) begin
                for (int k = 0; k < N; k++) e_fetch[k] = (c >= int'(ST) * k);
                check({name, "_run_rstn"},  64'(tile_rst_no),   64'hF);
                check({name, "_run_en"},    64'(tile_enable_o), 64'hF);
                check({name, "_run_fetch"}, 64'(fetch_en_o),    64'(e_fetch));
                check({name, "_run_busy"},  64'(busy_o),        64'h1);
                check({name, "_run_done"},  64'(done_o),        64'h0);
                check({name, "_run_cyc"},   64'(cycles_o),      64'(c));
            end else begin
                check({name, "_dn_rstn"},  64'(tile_rst_no),   64'hF);
                check({name, "_dn_en"},    64'(tile_enable_o), 64'h0);
                check({name, "_dn_fetch"}, 64'(fetch_en_o),    64'h0);
                check({name, "_dn_busy"},  64'(busy_o),        64'h0);
                check({name, "_dn_done"},  64'(done_o),        64'h1);
            end
            @(posedge clk); #1;
        end
        eoc_i   = '0;
        start_i = 1'b0;
        check({name, "_cycles"}, 64'(cycles_o),    64'(exp_end));
        check({name, "_tmo"},    64'(timeout_o),   64'(exp_tmo));
        check({name, "_fail"},   64'(fail_mask_o), 64'(exp_fail));
        check({name, "_pass"},   64'(pass_o),      64'(!exp_tmo && exp_fail == '0));
    endtask

    task automatic rand_scenario(input int idx);
        bit drop;
        bit has_real;
        int base;
        int t;
        clear_ev();
        drop = 1'b0;
        for (int k = 0; k < N; k++) begin
            base     = int'(ST) * k;
            has_real = ($urandom_range(0, 9) != 0);
            if (!has_real) drop = 1'b1;
            else begin
                ev_c[k][0]    = base + int'($urandom_range(0, 120));
                ev_code[k][0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h0;
                if ($urandom_range(0, 1) == 1) begin
                    ev_c[k][2]    = ev_c[k][0] + int'($urandom_range(1, 20));
                    ev_code[k][2] = 8'($urandom);
                end
            end
            if (k > 0 && $urandom_range(0, 1) == 1) begin
                ev_c[k][1]    = int'($urandom_range(0, base - 1));
                ev_code[k][1] = 8'($urandom);
            end
        end
        if (drop || $urandom_range(0, 1) == 1) t = int'($urandom_range(30, 200));
        else t = 0;
        run_seq($sformatf("rnd%0d", idx), t);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; timeout_cyc_i = '0; boot_addr_i = '0;
        eoc_i = '0; eoc_code_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        for (int k = 0; k < N; k++)
            check($sformatf("hartid%0d", k), 64'(mhartid_o[k*32 +: 32]), 64'(HB + k));
        rst_i = 1'b0;
        boot_addr_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check_reset_vals("idle");

        // all tiles succeed, staggered EOCs
        clear_ev();
        for (int k = 0; k < N; k++) ev_c[k][0] = 101 + k;
        run_seq("allok", 0);
        // tile 2 reports a nonzero exit code
        clear_ev();
        for (int k = 0; k < N; k++) ev_c[k][0] = 101 + k;
        ev_code[2][0] = 8'h05;
        run_seq("code5", 0);
        // tile 3 never finishes, timeout at 200
        clear_ev();
        ev_c[0][0] = 40; ev_c[1][0] = 50; ev_c[2][0] = 60;
        run_seq("tmo200", 200);
        // duplicate EOC on tile 0, early EOC on tile 3 before its launch
        clear_ev();
        ev_c[0][0] = 30; ev_c[0][1] = 35; ev_code[0][1] = 8'h07;
        ev_c[1][0] = 45; ev_c[2][0] = 55;
        ev_c[3][1] = 10; ev_code[3][1] = 8'h09; ev_c[3][0] = 70;
        run_seq("dupearly", 0);
        // simultaneous EOCs
        clear_ev();
        for (int k = 0; k < N; k++) ev_c[k][0] = 30;
        ev_code[1][0] = 8'h03;
        run_seq("simul", 0);
        // last EOC on the timeout cycle: completion wins
        clear_ev();
        ev_c[0][0] = 20; ev_c[1][0] = 30; ev_c[2][0] = 40; ev_c[3][0] = 60;
        run_seq("eoc_at_tmo", 60);
        // EOC on the timeout cycle captured, missing tile flagged
        clear_ev();
        ev_c[0][0] = 20; ev_c[1][0] = 30; ev_c[3][0] = 60;
        run_seq("tmo_partial", 60);

        // reset in the middle of RUN
        clear_ev();
        boot_addr_i = 32'h1234_5678; timeout_cyc_i = '0; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (L + 40) @(posedge clk);
        #1;
        check("midrun_busy", 64'(busy_o), 64'h1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check_reset_vals("midrst");
        clear_ev();
        for (int k = 0; k < N; k++) ev_c[k][0] = 40 + 3 * k;
        run_seq("after_rst", 0);

        for (int r = 0; r < 10; r++) rand_scenario(r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
